// File: rtl/serial_to_parallel_rx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_to_parallel_rx
//  Purpose  : Receives an LSB-first serial stream in which every bit is held
//             KEEP clock cycles inside a contiguous valid window, reassembles
//             DATAWIDTH-bit words and offers them on a ready/valid port backed
//             by a single holding register. Flags truncated frames and words
//             lost because the holding register was still full.
//  Options  : `define MAJORITY_VOTE_EN  -> each bit is decided by a ones-count
//             over its whole KEEP-cycle period (ties resolve to 0) instead of a
//             single mid-bit sample. Latency is identical in both builds.
//  Ports    : clk              system clock, all state on rising edge
//             rst              asynchronous active-high reset
//             i_SerialIn       serial data bit, LSB first
//             i_SerialInValid  high for the DATAWIDTH*KEEP cycles of a frame
//             o_DataOut        assembled word
//             o_DataOutValid   o_DataOut holds an unconsumed word
//             i_DataOutReady   consumer takes the word on valid & ready
//             o_FrameErr       one-cycle pulse: frame aborted early
//             o_Overrun        one-cycle pulse: completed word dropped
//  Revision : 1.0  initial release
// ============================================================================
module serial_to_parallel_rx #(
    parameter int DATAWIDTH = 8,
    parameter int KEEP      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_SerialIn,
    input  logic                 i_SerialInValid,
    output logic [DATAWIDTH-1:0] o_DataOut,
    output logic                 o_DataOutValid,
    input  logic                 i_DataOutReady,
    output logic                 o_FrameErr,
    output logic                 o_Overrun
);

    localparam int c_KEEP_W = $clog2(KEEP) + 1;
    localparam int c_BIT_W  = $clog2(DATAWIDTH) + 1;
    localparam int c_IDX_W  = $clog2(DATAWIDTH);

    localparam logic [c_KEEP_W-1:0] c_KEEP_LAST = c_KEEP_W'(KEEP - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATAWIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_KEEP_W-1:0]    r_keep_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [DATAWIDTH-1:0]   r_shift;
    logic [DATAWIDTH-1:0]   r_data_out;
    logic                   r_data_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_active;     // this cycle carries a frame bit
    logic                   w_abort;      // valid dropped mid-frame
    logic                   w_bit_end;    // last cycle of a bit period
    logic                   w_complete;   // last cycle of the whole frame
    logic                   w_bit_wr;     // write the decided bit this cycle
    logic                   w_bit_val;
    logic [DATAWIDTH-1:0]   w_word;       // shift register incl. this cycle's bit

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle control strobes.
    // The first valid cycle seen in S_IDLE is already cycle 0 of bit 0, so
    // it is processed as an active cycle with the (cleared) counters.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_SerialInValid) begin
                    w_active    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_SerialInValid) begin
                    w_active = 1'b1;
                end else begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (!i_SerialInValid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_bit_end  = w_active && (r_keep_cnt == c_KEEP_LAST);
        w_complete = w_bit_end && (r_bit_cnt == c_BIT_LAST);
        if (w_complete) begin
            w_state_nxt = S_GAP;
        end
    end

    // ------------------------------------------------------------------
    // Bit decision
    // ------------------------------------------------------------------
`ifdef MAJORITY_VOTE_EN
    logic [c_KEEP_W-1:0] r_ones;
    logic [c_KEEP_W:0]   w_ones_total;   // ones seen so far including this cycle

    assign w_ones_total = {1'b0, r_ones} + (c_KEEP_W + 1)'(i_SerialIn);
    assign w_bit_wr     = w_bit_end;
    // Strict majority: 2*ones > KEEP, so an even-KEEP tie decides 0.
    assign w_bit_val    = ({w_ones_total, 1'b0} > (c_KEEP_W + 2)'(KEEP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= '0;
        end else if (w_abort || w_bit_end) begin
            r_ones <= '0;
        end else if (w_active) begin
            r_ones <= r_ones + c_KEEP_W'(i_SerialIn);
        end
    end
`else
    localparam logic [c_KEEP_W-1:0] c_SAMPLE = c_KEEP_W'(KEEP / 2);

    assign w_bit_wr  = w_active && (r_keep_cnt == c_SAMPLE);
    assign w_bit_val = i_SerialIn;
`endif

    always_comb begin
        w_word = r_shift;
        if (w_bit_wr) begin
            w_word[r_bit_cnt[c_IDX_W-1:0]] = w_bit_val;
        end
    end

    // ------------------------------------------------------------------
    // Counters, shift register and output holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keep_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_abort;
            r_overrun   <= 1'b0;

            if (w_abort || w_complete) begin
                r_keep_cnt <= '0;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
            end else if (w_active) begin
                r_shift <= w_word;
                if (w_bit_end) begin
                    r_keep_cnt <= '0;
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end else begin
                    r_keep_cnt <= r_keep_cnt + 1'b1;
                end
            end

            // A completion may replace the held word only if it is empty or
            // being consumed on this very edge; otherwise the new word is lost.
            if (w_complete) begin
                if (!r_data_valid || i_DataOutReady) begin
                    r_data_out   <= w_word;
                    r_data_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_data_valid && i_DataOutReady) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign o_DataOut      = r_data_out;
    assign o_DataOutValid = r_data_valid;
    assign o_FrameErr     = r_frame_err;
    assign o_Overrun      = r_overrun;

endmodule
`default_nettype wire
